// File: rtl/cfg_seq_pkg.sv
// cfg_seq_pkg: shared op codes, address field positions and FSM states for the config sequencer
package cfg_seq_pkg;
  localparam logic [7:0] OP_WRITE = 8'h00;
  localparam logic [7:0] OP_READ = 8'h01;
  localparam int TILE_LSB = 0;
  localparam int TILE_MSB = 15;
  localparam int REG_LSB = 16;
  localparam int REG_MSB = 23;
  localparam int OP_LSB = 24;
  localparam int OP_MSB = 31;
  typedef enum logic [1:0] {IDLE, WR, RD, WAIT} state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic last;
  } word_t;
endpackage

// File: rtl/cfg_stream_sequencer_if.sv
// cfg_stream_sequencer_if: valid/ready config word stream into the sequencer
interface cfg_stream_sequencer_if;
  logic s_valid;
  logic s_ready;
  logic [31:0] s_addr;
  logic [31:0] s_data;
  logic s_last;
  modport master (output s_valid, s_addr, s_data, s_last, input s_ready);
  modport slave (input s_valid, s_addr, s_data, s_last, output s_ready);
endinterface

// File: rtl/cfg_seq_fifo.sv
// cfg_seq_fifo: power-of-two synchronous FIFO with show-ahead head output
module cfg_seq_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic clk_in,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign dout = mem[rp[AW-1:0]];
  // pointers carry an extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clk_in) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + 1'b1;
      end
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/cfg_stream_sequencer.sv
// cfg_stream_sequencer: buffers config words and replays matching ones as tile write/read strobes
module cfg_stream_sequencer
  import cfg_seq_pkg::*;
#(
  parameter logic [15:0] TILE_ID = 16'h0018,
  parameter int FIFO_DEPTH = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic clk_in,
  input  logic reset,
  cfg_stream_sequencer_if.slave s,
  output logic [31:0] cfg_addr,
  output logic [31:0] cfg_data,
  output logic cfg_write,
  output logic cfg_read,
  input  logic [31:0] read_data,
  output logic rd_valid,
  output logic [31:0] rd_data,
  output logic done,
  output logic [7:0] drop_count
);
  state_t state, nxt;
  word_t head;
  logic full, empty, push, pop, is_wr, is_rd, rd_done, cur_last;
  logic [2:0] cnt;
  assign s.s_ready = !full && !reset;
  assign push = s.s_valid && s.s_ready;
  assign is_wr = head.addr[TILE_MSB:TILE_LSB] == TILE_ID && head.addr[OP_MSB:OP_LSB] == OP_WRITE;
  assign is_rd = head.addr[TILE_MSB:TILE_LSB] == TILE_ID && head.addr[OP_MSB:OP_LSB] == OP_READ;
  assign rd_done = READ_LATENCY == 1 ? state == RD : state == WAIT && cnt == 3'(READ_LATENCY - 2);
  cfg_seq_fifo #(.WIDTH($bits(word_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in(clk_in),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din({s.s_addr, s.s_data, s.s_last}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  // next state and strobes; only IDLE ever pops the buffer
  always_comb begin
    pop = state == IDLE && !empty;
    nxt = pop && is_wr ? WR : pop && is_rd ? RD : state == RD && READ_LATENCY > 1 ? WAIT : state == WAIT && !rd_done ? WAIT : IDLE;
    cfg_write = state == WR;
    cfg_read = state == RD;
  end
  // state, wait counter, captured tile bus values, readback and status
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      cfg_addr <= '0;
      cfg_data <= '0;
      rd_valid <= 1'b0;
      rd_data <= '0;
      done <= 1'b0;
      drop_count <= '0;
      cur_last <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      rd_valid <= rd_done;
      if (rd_done) rd_data <= read_data;
      if (pop && (is_wr || is_rd)) begin
        cfg_addr <= head.addr;
        cur_last <= head.last;
      end
      if (pop && is_wr) cfg_data <= head.data;
      if (pop && !is_wr && !is_rd && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
      if ((pop && !is_wr && !is_rd && head.last) || (state == WR && cur_last) || (rd_done && cur_last)) done <= 1'b1;
    end
  end
endmodule
